// File: rtl/oversample_phase_aligner.sv
// Recovers 2 data bits per clock from 8 phase-interleaved samples and picks the cleanest sample phase.
// Define PHASE_SEL_EXTERNAL_EN to take the phase select from phase_sel_in instead of the auto-tracking FSM.
module oversample_phase_aligner (
  input  logic       fastclock,
  input  logic       reset_i,
  input  logic [7:0] samples_i,
  input  logic       invert,
  input  logic [1:0] phase_sel_in,
  input  logic [7:0] stable_count_to_reset,
  input  logic [7:0] err_count_to_shift,
  output logic [1:0] phase_sel_out,
  output logic       phase_err,
  output logic       d0,
  output logic       d1
);

  logic [7:0] ii_p1;
  logic [7:0] id_p2;
  logic [3:0] eq_p2;
  logic [3:0] perr;
  logic [1:0] sel;
  logic       rising;
  logic       falling;
  logic       rising_p3;
  logic       falling_p3;

  function automatic logic [7:0] sat_inc(input logic [7:0] count, input logic [7:0] limit);
    return (count < limit) ? count + 8'd1 : count;
  endfunction

  // Stage 1/2: capture, normalise polarity, flag edges between neighbouring samples
  always_ff @(posedge fastclock) begin
    if (reset_i) begin
      ii_p1 <= 8'h00;
      id_p2 <= 8'h00;
      eq_p2 <= 4'h0;
    end else begin
      ii_p1    <= samples_i;
      id_p2    <= ii_p1 ^ 8'h55;
      eq_p2[0] <= (ii_p1[0] == ii_p1[1]) | (ii_p1[4] == ii_p1[5]);
      eq_p2[1] <= (ii_p1[1] == ii_p1[2]) | (ii_p1[5] == ii_p1[6]);
      eq_p2[2] <= (ii_p1[2] == ii_p1[3]) | (ii_p1[6] == ii_p1[7]);
      eq_p2[3] <= (ii_p1[3] == ii_p1[4]) | (id_p2[7] == ii_p1[0]);
    end
  end

  assign perr = eq_p2 | {eq_p2[2:0], eq_p2[3]};

  always_comb begin
    falling = id_p2[0];
    rising  = id_p2[4];
    case (sel)
      2'b00: begin falling = id_p2[0]; rising = id_p2[4]; end
      2'b01: begin falling = id_p2[1]; rising = id_p2[5]; end
      2'b11: begin falling = id_p2[2]; rising = id_p2[6]; end
      2'b10: begin falling = id_p2[3]; rising = id_p2[7]; end
    endcase
  end

  // Stage 3/4: selected bits and phase error, then output register
  always_ff @(posedge fastclock) begin
    if (reset_i) begin
      rising_p3  <= 1'b0;
      falling_p3 <= 1'b0;
      phase_err  <= 1'b0;
      d0         <= 1'b0;
      d1         <= 1'b0;
    end else begin
      rising_p3  <= rising ^ invert;
      falling_p3 <= falling ^ invert;
      phase_err  <= perr[sel];
      d0         <= rising_p3;
      d1         <= falling_p3;
    end
  end

`ifdef PHASE_SEL_EXTERNAL_EN
  logic [1:0] sel_ext;
  logic       unused_thr;

  assign unused_thr = ^{stable_count_to_reset, err_count_to_shift};

  always_ff @(posedge fastclock) begin
    if (reset_i) begin
      sel_ext <= 2'b00;
    end else begin
      sel_ext <= phase_sel_in;
    end
  end

  assign sel           = sel_ext;
  assign phase_sel_out = sel_ext;
`else
  localparam logic [1:0] PH_A = 2'b00;
  localparam logic [1:0] PH_B = 2'b01;
  localparam logic [1:0] PH_C = 2'b11;
  localparam logic [1:0] PH_D = 2'b10;

  logic [7:0] stable_count;
  logic [7:0] err_count;
  logic       link_stable;
  logic       vote;
  logic [1:0] sm;
  logic [1:0] sm_last;
  logic [1:0] sm_next;
  logic       unused_sel;

  assign unused_sel = ^phase_sel_in;

  // An edge on the early side of the current phase moves it one step later, and vice versa
  always_comb begin
    sm_next = sm;
    if (vote) begin
      case (sm)
        PH_A: if (eq_p2[0]) sm_next = PH_D; else if (eq_p2[3]) sm_next = PH_B;
        PH_B: if (eq_p2[1]) sm_next = PH_A; else if (eq_p2[0]) sm_next = PH_C;
        PH_C: if (eq_p2[2]) sm_next = PH_B; else if (eq_p2[1]) sm_next = PH_D;
        PH_D: if (eq_p2[3]) sm_next = PH_C; else if (eq_p2[2]) sm_next = PH_A;
      endcase
    end
  end

  always_ff @(posedge fastclock) begin
    if (reset_i) begin
      stable_count <= 8'd0;
      err_count    <= 8'd0;
      link_stable  <= 1'b0;
      vote         <= 1'b0;
      sm           <= PH_A;
      sm_last      <= PH_A;
    end else begin
      stable_count <= phase_err ? 8'd0 : sat_inc(stable_count, stable_count_to_reset);
      link_stable  <= (stable_count == stable_count_to_reset);
      sm_last      <= sm;
      vote         <= (err_count == err_count_to_shift);
      if (link_stable || (sm_last != sm)) begin
        err_count <= 8'd0;
      end else if (phase_err) begin
        err_count <= sat_inc(err_count, err_count_to_shift);
      end
      sm <= sm_next;
    end
  end

  assign sel           = sm;
  assign phase_sel_out = sm;
`endif

endmodule

// File: tb/tb_oversample_phase_aligner.sv
// Bench for oversample_phase_aligner: fixed vectors, corner sequences, and random traffic against a reference model.
module tb_oversample_phase_aligner;

  logic       fastclock = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] samples_i = 8'h00;
  logic       invert = 1'b0;
  logic [1:0] phase_sel_in = 2'b00;
  logic [7:0] stable_count_to_reset = 8'hFF;
  logic [7:0] err_count_to_shift = 8'hFF;
  logic [1:0] phase_sel_out;
  logic       phase_err;
  logic       d0;
  logic       d1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 fastclock = ~fastclock;

  oversample_phase_aligner dut (
    .fastclock(fastclock),
    .reset_i(reset_i),
    .samples_i(samples_i),
    .invert(invert),
    .phase_sel_in(phase_sel_in),
    .stable_count_to_reset(stable_count_to_reset),
    .err_count_to_shift(err_count_to_shift),
    .phase_sel_out(phase_sel_out),
    .phase_err(phase_err),
    .d0(d0),
    .d1(d1)
  );

  // Reference model: state after each clock edge, in terms of sample words and phase slots
  logic [7:0] m_raw, m_norm;
  logic [3:0] m_eq;
  logic       m_rise, m_fall, m_perr, m_d0, m_d1, m_link, m_vote;
  logic [1:0] m_slot, m_prev_slot, m_ext;
  int         m_stable, m_err;

  // Slots are ordered by sampling time; the select code is their Gray encoding
  function automatic logic [1:0] slot_code(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  function automatic logic [1:0] code_slot(input logic [1:0] c);
    return {c[1], c[1] ^ c[0]};
  endfunction

  // A transition in the true-polarity stream at boundary j falls into edge class j mod 4
  function automatic logic [3:0] edge_classes(input logic [7:0] n, input logic prev7);
    logic [3:0] r;
    r = 4'h0;
    for (int j = 0; j < 7; j++) if (n[j] != n[j+1]) r[j%4] = 1'b1;
    if (prev7 != n[0]) r[3] = 1'b1;
    return r;
  endfunction

  function automatic logic [1:0] model_sel();
`ifdef PHASE_SEL_EXTERNAL_EN
    return m_ext;
`else
    return slot_code(m_slot);
`endif
  endfunction

  task automatic model_step();
    logic [1:0] sel, k, n_slot;
    logic [3:0] n_eq;
    logic       n_rise, n_fall, n_perr, n_link, n_vote;
    int         n_stable, n_err;
    if (reset_i) begin
      m_raw = 8'h00; m_norm = 8'h00; m_eq = 4'h0;
      m_rise = 1'b0; m_fall = 1'b0; m_perr = 1'b0; m_d0 = 1'b0; m_d1 = 1'b0;
      m_link = 1'b0; m_vote = 1'b0; m_slot = 2'd0; m_prev_slot = 2'd0; m_ext = 2'd0;
      m_stable = 0; m_err = 0;
    end else begin
      sel    = model_sel();
      k      = code_slot(sel);
      n_eq   = edge_classes(m_raw ^ 8'h55, m_norm[7]);
      n_fall = m_norm[{1'b0, k}] ^ invert;
      n_rise = m_norm[{1'b1, k}] ^ invert;
      n_perr = m_eq[sel] | m_eq[sel - 2'd1];
      n_stable = m_perr ? 0 : ((m_stable < int'(stable_count_to_reset)) ? m_stable + 1 : m_stable);
      n_link   = (m_stable == int'(stable_count_to_reset));
      n_vote   = (m_err == int'(err_count_to_shift));
      if (m_link || (m_prev_slot != m_slot)) n_err = 0;
      else if (m_perr && (m_err < int'(err_count_to_shift))) n_err = m_err + 1;
      else n_err = m_err;
      n_slot = m_slot;
      if (m_vote) begin
        if (m_eq[m_slot]) n_slot = m_slot - 2'd1;
        else if (m_eq[m_slot - 2'd1]) n_slot = m_slot + 2'd1;
      end
      m_d0 = m_rise; m_d1 = m_fall;
      m_rise = n_rise; m_fall = n_fall; m_perr = n_perr;
      m_norm = m_raw ^ 8'h55; m_raw = samples_i; m_eq = n_eq;
      m_stable = n_stable; m_link = n_link; m_vote = n_vote; m_err = n_err;
      m_prev_slot = m_slot; m_slot = n_slot; m_ext = phase_sel_in;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge fastclock);
    #1;
    check("model", int'({phase_sel_out, phase_err, d1, d0}),
          int'({model_sel(), m_perr, m_d1, m_d0}));
  endtask

  task automatic hold(input logic [7:0] w, input int n, output int errs);
    errs = 0;
    samples_i = w;
    repeat (n) begin
      tick();
      errs += int'(phase_err);
    end
  endtask

  task automatic do_reset(input logic [7:0] shift, input logic [7:0] stab);
    err_count_to_shift = shift;
    stable_count_to_reset = stab;
    reset_i = 1'b1;
    repeat (2) tick();
    reset_i = 1'b0;
  endtask

  typedef struct {
    logic [7:0] samples;
    logic       inv;
    logic       d0;
    logic       d1;
    logic       perr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int e1, e2;
    tbl[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hAA, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h55, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'hAA, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h96, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h96, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h33, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with random samples, then first valid data 4 clocks after release
    reset_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      samples_i = 8'($urandom);
      tick();
      check("rst_outs", int'({phase_sel_out, phase_err, d1, d0}), 0);
    end
    reset_i = 1'b0;
    samples_i = 8'hAA;
    tick();
    check("rst_flush_d0", int'(d0), 0);
    repeat (3) tick();
    check("rst_first_d0", int'(d0), 1);
    check("rst_first_d1", int'(d1), 1);

    // Static patterns
    for (int i = 0; i < 7; i++) begin
      samples_i = tbl[i].samples;
      invert = tbl[i].inv;
      repeat (6) tick();
      check("vec_d0", int'(d0), int'(tbl[i].d0));
      check("vec_d1", int'(d1), int'(tbl[i].d1));
      check("vec_perr", int'(phase_err), int'(tbl[i].perr));
      check("vec_sel", int'(phase_sel_out), 0);
    end
    invert = 1'b0;

    // Latency of a single changed word
    do_reset(8'hFF, 8'hFF);
    hold(8'h55, 8, e1);
    samples_i = 8'hAA;
    tick();
    check("lat_perr_1", int'(phase_err), 0);
    samples_i = 8'h55;
    tick();
    check("lat_perr_2", int'(phase_err), 0);
    tick();
    check("lat_perr_3", int'(phase_err), 1);
    check("lat_d0_3", int'(d0), 0);
    tick();
    check("lat_d0_4", int'(d0), 1);
    check("lat_d1_4", int'(d1), 1);
    tick();
    check("lat_d0_5", int'(d0), 0);

`ifndef PHASE_SEL_EXTERNAL_EN
    // Persistent edges between samples 0 and 1 push the phase to 10
    do_reset(8'd4, 8'd200);
    samples_i = 8'h4B;
    for (int i = 0; i < 40 && phase_sel_out != 2'b10; i++) tick();
    check("shift_reached", int'(phase_sel_out), 2);
    hold(8'h4B, 6, e1);
    check("shift_sel", int'(phase_sel_out), 2);
    check("shift_perr", int'(phase_err), 0);
    check("shift_d0", int'(d0), 0);
    check("shift_d1", int'(d1), 1);

    // Error bursts separated by a long clean run must not shift
    do_reset(8'd4, 8'd200);
    hold(8'h55, 215, e1);
    hold(8'h4B, 3, e1);
    hold(8'h55, 205, e2);
    check("stab_burst1", e1 + e2, 3);
    hold(8'h4B, 3, e1);
    hold(8'h55, 20, e2);
    check("stab_burst2", e1 + e2, 3);
    check("stab_sel", int'(phase_sel_out), 0);

    // err_count_to_shift = 0 keeps voting; stable_count_to_reset = 0 blocks shifting
    do_reset(8'd0, 8'd200);
    hold(8'h4B, 10, e1);
    check("zero_shift_sel", int'(phase_sel_out), 2);
    do_reset(8'd4, 8'd0);
    hold(8'h4B, 30, e1);
    check("zero_stable_sel", int'(phase_sel_out), 0);
    check("zero_stable_perr", int'(phase_err), 1);
`else
    // External phase select
    do_reset(8'hFF, 8'hFF);
    samples_i = 8'h96;
    phase_sel_in = 2'b11;
    tick();
    check("ext_sel", int'(phase_sel_out), 3);
    hold(8'h96, 6, e1);
    check("ext_d0", int'(d0), 1);
    check("ext_d1", int'(d1), 0);
    check("ext_perr", int'(phase_err), 0);
`endif

    // Random traffic against the model
    for (int seg = 0; seg < 3; seg++) begin
      do_reset(8'($urandom_range(0, 5)), 8'($urandom_range(0, 12)));
      invert = 1'($urandom);
      repeat (300) begin
        if ($urandom_range(0, 3) == 0) samples_i = 8'($urandom);
        reset_i = ($urandom_range(0, 199) == 0);
        phase_sel_in = 2'($urandom);
        tick();
      end
      reset_i = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
